// File: rtl/beamform_pkg.sv
// Shared beamformer constants, reader FSM state type and a sample sign-extension helper.
package beamform_pkg;

  localparam int NUM_CH       = 16;
  localparam int DELTA_LAST   = 256;
  localparam int DELTA_W      = $clog2(DELTA_LAST);
  localparam int DEPTH        = 2 ** DELTA_W;
  localparam int PIXEL_COLUMN = 128;
  localparam int PIXEL_ROW    = 64;
  localparam int PIX_X_W      = $clog2(PIXEL_COLUMN);
  localparam int PIX_Y_W      = $clog2(PIXEL_ROW);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    OUT
  } state_t;

  // Treats the low `width` bits of raw as two's complement; callers truncate to their sum width.
  function automatic logic signed [63:0] sign_extend(input logic [63:0] raw, input int width);
    logic signed [63:0] t;
    t = $signed(raw << (64 - width));
    return t >>> (64 - width);
  endfunction

endpackage

// File: rtl/delay_sum_reader_if.sv
// Sample-frame write bus, pixel request handshake and sum result handshake of the delay-sum reader.
interface delay_sum_reader_if #(
  parameter int DATA_W = 16,
  parameter int SUM_W  = DATA_W + 4
);
  import beamform_pkg::*;

  logic                               i_sample_valid;
  logic [NUM_CH-1:0][DATA_W-1:0]      i_sample;
  logic                               i_req_valid;
  logic                               o_req_ready;
  logic signed [PIX_X_W-1:0]          i_p_x;
  logic signed [PIX_Y_W-1:0]          i_p_y;
  logic [NUM_CH-1:0][DELTA_W-1:0]     i_delta;
  logic                               o_sum_valid;
  logic                               i_sum_ready;
  logic signed [SUM_W-1:0]            o_sum;
  logic signed [PIX_X_W-1:0]          o_p_x;
  logic signed [PIX_Y_W-1:0]          o_p_y;

  modport master (
    output i_sample_valid, i_sample, i_req_valid, i_p_x, i_p_y, i_delta, i_sum_ready,
    input  o_req_ready, o_sum_valid, o_sum, o_p_x, o_p_y
  );

  modport slave (
    input  i_sample_valid, i_sample, i_req_valid, i_p_x, i_p_y, i_delta, i_sum_ready,
    output o_req_ready, o_sum_valid, o_sum, o_p_x, o_p_y
  );

endinterface

// File: rtl/sample_ring.sv
// One channel's sample history: synchronous write, combinational read, contents never reset.
module sample_ring #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_sum_reader.sv
// Delay-and-sum reader: per-channel ring buffers, one request at a time, one channel summed per cycle.
module delay_sum_reader
  import beamform_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SUM_W  = DATA_W + 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  delay_sum_reader_if.slave bus
);

  localparam int CH_W = $clog2(NUM_CH);

  state_t                         state, state_nxt;
  logic [DELTA_W-1:0]             wptr, wsnap;
  logic [DELTA_W:0]               fill, fsnap;
  logic [NUM_CH-1:0][DELTA_W-1:0] delta_q;
  logic signed [PIX_X_W-1:0]      px_q;
  logic signed [PIX_Y_W-1:0]      py_q;
  logic signed [SUM_W-1:0]        acc;
  logic [CH_W-1:0]                ch;
  logic [DELTA_W-1:0]             ring_raddr [NUM_CH];
  logic [DATA_W-1:0]              ring_rdata [NUM_CH];
  logic [DATA_W-1:0]              sel_sample;
  logic [DELTA_W-1:0]             sel_delta;
  logic                           masked;
  logic signed [SUM_W-1:0]        term;
  logic                           accept;

  // Addresses come from the snapshot, so they always trail wptr and never collide with a write.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ring
    assign ring_raddr[g] = wsnap - DELTA_W'(1) - delta_q[g];

    sample_ring #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (DELTA_W)
    ) u_ring (
      .clk   (i_clk),
      .we    (bus.i_sample_valid),
      .waddr (wptr),
      .wdata (bus.i_sample[g]),
      .raddr (ring_raddr[g]),
      .rdata (ring_rdata[g])
    );
  end

  assign accept     = (state == IDLE) && bus.i_req_valid;
  assign sel_sample = ring_rdata[ch];
  assign sel_delta  = delta_q[ch];
  assign masked     = ({1'b0, sel_delta} >= fsnap);
  assign term       = masked ? '0 : SUM_W'(sign_extend(64'(sel_sample), DATA_W));

  // Fill saturates at DEPTH, which is exactly when its MSB becomes set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0;
      fill <= '0;
    end else if (bus.i_sample_valid) begin
      wptr <= wptr + 1'b1;
      if (!fill[DELTA_W]) begin
        fill <= fill + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_req_valid) state_nxt = READ;
      READ:    if (ch == CH_W'(NUM_CH - 1)) state_nxt = OUT;
      OUT:     if (bus.i_sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      delta_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      wsnap   <= '0;
      fsnap   <= '0;
      acc     <= '0;
      ch      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            delta_q <= bus.i_delta;
            px_q    <= bus.i_p_x;
            py_q    <= bus.i_p_y;
            wsnap   <= wptr;
            fsnap   <= fill;
            acc     <= '0;
            ch      <= '0;
          end
        end
        READ: begin
          acc <= acc + term;
          ch  <= ch + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_req_ready = (state == IDLE);
  assign bus.o_sum_valid = (state == OUT);
  assign bus.o_sum       = acc;
  assign bus.o_p_x       = px_q;
  assign bus.o_p_y       = py_q;

endmodule

// File: tb/tb_delay_sum_reader.sv
// Directed bench for delay_sum_reader: frame fills, delayed reads, masking, wrap, backpressure, reset.
module tb_delay_sum_reader;
  import beamform_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   frame_no   = 0;
  logic [NUM_CH-1:0][DELTA_W-1:0] delta_vec;

  delay_sum_reader_if bus ();

  delay_sum_reader dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change only at the falling edge; frame_no counts frames the DUT has actually written.
  task automatic stepCycle();
    @(negedge i_clk);
    if (bus.i_sample_valid) frame_no++;
  endtask

  task automatic driveFrame(input int mode);
    for (int k = 0; k < NUM_CH; k++) begin
      case (mode)
        0:       bus.i_sample[k] = 16'(frame_no);
        1:       bus.i_sample[k] = 16'(-(k + 1));
        default: bus.i_sample[k] = 16'(100);
      endcase
    end
    bus.i_sample_valid = 1'b1;
  endtask

  task automatic writeFrames(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      driveFrame(mode);
      stepCycle();
    end
    bus.i_sample_valid = 1'b0;
  endtask

  task automatic resetDut();
    i_rst_n = 1'b0;
    bus.i_sample_valid = 1'b0;
    bus.i_req_valid    = 1'b0;
    bus.i_sum_ready    = 1'b0;
    stepCycle();
    stepCycle();
    i_rst_n  = 1'b1;
    frame_no = 0;
    stepCycle();
  endtask

  task automatic setDeltas(input int base, input int step);
    for (int k = 0; k < NUM_CH; k++) delta_vec[k] = DELTA_W'(base + step * k);
  endtask

  task automatic applyStimulus(input string tag, input int px, input int py, input bit concurrent,
                               input int hold, input bit handshake, input int exp_sum);
    int lat;
    bus.i_p_x       = PIX_X_W'(px);
    bus.i_p_y       = PIX_Y_W'(py);
    bus.i_delta     = delta_vec;
    bus.i_req_valid = 1'b1;
    if (concurrent) driveFrame(0);
    stepCycle();
    bus.i_req_valid = 1'b0;
    bus.i_p_x       = '0;
    bus.i_p_y       = '0;
    bus.i_delta     = '0;
    lat = 1;
    checkOutput({tag, ".ready_low"}, bus.o_req_ready, 0);
    while (!bus.o_sum_valid && lat < 40) begin
      if (concurrent) driveFrame(0);
      stepCycle();
      lat++;
    end
    bus.i_sample_valid = 1'b0;
    checkOutput({tag, ".latency"}, lat, 17);
    checkOutput({tag, ".sum"}, bus.o_sum, exp_sum);
    checkOutput({tag, ".p_x"}, bus.o_p_x, px);
    checkOutput({tag, ".p_y"}, bus.o_p_y, py);
    for (int i = 0; i < hold; i++) begin
      stepCycle();
      checkOutput({tag, ".hold_sum"}, bus.o_sum, exp_sum);
      checkOutput({tag, ".hold_ready"}, bus.o_req_ready, 0);
    end
    if (handshake) begin
      bus.i_sum_ready = 1'b1;
      stepCycle();
      bus.i_sum_ready = 1'b0;
      checkOutput({tag, ".valid_drop"}, bus.o_sum_valid, 0);
      checkOutput({tag, ".ready_back"}, bus.o_req_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_sample_valid = 1'b0;
    bus.i_sample       = '0;
    bus.i_req_valid    = 1'b0;
    bus.i_p_x          = '0;
    bus.i_p_y          = '0;
    bus.i_delta        = '0;
    bus.i_sum_ready    = 1'b0;
    delta_vec          = '0;
    i_rst_n            = 1'b1;
    #1 i_rst_n = 1'b0;
    @(negedge i_clk);
    checkOutput("reset.sum_valid", bus.o_sum_valid, 0);
    checkOutput("reset.sum", bus.o_sum, 0);
    i_rst_n = 1'b1;
    stepCycle();
    checkOutput("release.ready", bus.o_req_ready, 1);
    checkOutput("release.sum_valid", bus.o_sum_valid, 0);
    checkOutput("release.sum", bus.o_sum, 0);
    checkOutput("release.p_x", bus.o_p_x, 0);
    checkOutput("release.p_y", bus.o_p_y, 0);

    $display("[TB] empty buffer request");
    setDeltas(0, 0);
    applyStimulus("empty", 1, 1, 1'b0, 0, 1'b1, 0);

    $display("[TB] single tap, delta 147");
    resetDut();
    writeFrames(200, 0);
    setDeltas(147, 0);
    applyStimulus("single_tap", -5, 3, 1'b0, 0, 1'b1, 832);

    $display("[TB] mixed deltas, negative samples");
    resetDut();
    writeFrames(200, 1);
    setDeltas(147, 1);
    applyStimulus("mixed", 63, -32, 1'b0, 0, 1'b1, -136);

    $display("[TB] partial fill masking");
    resetDut();
    writeFrames(150, 2);
    for (int k = 0; k < NUM_CH; k++) delta_vec[k] = (k < 8) ? DELTA_W'(147) : DELTA_W'(160);
    applyStimulus("partial", 10, 20, 1'b0, 0, 1'b1, 800);
    setDeltas(150, 0);
    delta_vec[0] = DELTA_W'(149);
    applyStimulus("fill_edge", -64, 31, 1'b0, 0, 1'b1, 100);

    $display("[TB] write same cycle as accept");
    resetDut();
    writeFrames(5, 0);
    setDeltas(0, 0);
    applyStimulus("same_cycle", 2, 2, 1'b1, 0, 1'b1, 64);

    $display("[TB] wrap with writes during read");
    resetDut();
    writeFrames(300, 0);
    setDeltas(179, 0);
    applyStimulus("wrap", 7, -7, 1'b1, 0, 1'b1, 1920);

    $display("[TB] backpressure then reset in OUT");
    resetDut();
    writeFrames(10, 2);
    setDeltas(0, 0);
    applyStimulus("backpressure", -1, -1, 1'b0, 10, 1'b0, 1600);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("async_rst.sum_valid", bus.o_sum_valid, 0);
    checkOutput("async_rst.sum", bus.o_sum, 0);
    checkOutput("async_rst.ready", bus.o_req_ready, 1);
    stepCycle();
    i_rst_n  = 1'b1;
    frame_no = 0;
    stepCycle();
    applyStimulus("after_reset", 4, 5, 1'b0, 0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/delay_sum_reader.md
# delay_sum_reader

Reader side of the per-pixel delay interface. The block stores incoming 16-channel sample frames in per-channel ring buffers. It accepts one pixel request carrying the 16 delay indices produced by the delay generator, reads each channel's sample at its delay, and returns the delay-and-sum value for that pixel. It sits between the sensor sample front end and the pixel image accumulator.

## Interface

**Parameters**
- `DATA_W`, default 16: signed sample width.
- `SUM_W`, default `DATA_W+4`: signed output sum width. Sixteen terms cannot overflow at this width.

**Ports** (`DELTA_W` = `$clog2(`DELTA_LAST)`)
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `i_sample_valid`, in, 1: writes one frame this cycle.
- `i_sample[15:0]`, in, signed DATA_W each: the frame, one sample per channel.
- `i_req_valid`, in, 1: pixel request.
- `o_req_ready`, out, 1: request accepted when both valid and ready are high.
- `i_p_x`, in, signed `$clog2(`PIXEL_COLUMN)`: pixel tag.
- `i_p_y`, in, signed `$clog2(`PIXEL_ROW)`: pixel tag.
- `i_delta[15:0]`, in, DELTA_W each: per-channel delay in frames.
- `o_sum_valid`, out, 1: result valid.
- `i_sum_ready`, in, 1: downstream accepts the result.
- `o_sum`, out, signed SUM_W: delay-and-sum result.
- `o_p_x`, `o_p_y`, out: pixel tag returned with the sum.

## Operation

**Storage**
- `DEPTH` = 2**DELTA_W (256 for the current build).
- Each channel has its own ring buffer of DEPTH entries.
- Write pointer `wptr` (DELTA_W bits) advances by 1 on each `i_sample_valid` and wraps modulo DEPTH.
- Fill counter `fill` (DELTA_W+1 bits) increments on each write and saturates at DEPTH.

**Request capture**
- On accept, the block latches the 16 deltas and the pixel tag.
- It also snapshots `wptr` and `fill` as `wsnap` and `fsnap`.

**Read address and masking**
- Channel k address = (`wsnap` − 1 − `delta[k]`) mod DEPTH. Delta 0 is the newest frame at accept time.
- If `delta[k]` ≥ `fsnap`, channel k contributes 0, because that frame has never been written.

**State machine**
- IDLE: `o_req_ready`=1. On accept, go to READ with the accumulator cleared and ch=0.
- READ: adds the sign-extended sample of channel `ch` to the accumulator, then increments `ch`. After ch=15, go to OUT.
- OUT: `o_sum_valid`=1 and outputs are stable. When `i_sum_ready`=1, go to IDLE.

**Concurrency**
- Sample writes continue in every state and never stall.
- Reads use the snapshot, so frames written during READ do not change the result.
- At most 16 frames can arrive during READ. Reads stay valid while (delta + 17) < DEPTH, which holds for all delta ≤ 179.
- The block never drops or overwrites a pending result.

## Timing

**Reset values**
- `o_req_ready`=1 after reset release.
- `o_sum_valid`=0, `o_sum`=0, `o_p_x`=0, `o_p_y`=0.
- `wptr`=0, `fill`=0, state=IDLE.
- Buffer contents are not reset; the fill mask covers them.

**Latency and throughput**
- Accept at cycle 0. READ runs cycles 1–16. `o_sum_valid` rises at cycle 17.
- Throughput is one pixel per 18 cycles when `i_sum_ready` is held high.
- `o_req_ready` drops the cycle after accept and stays 0 until the cycle after the OUT handshake.

**Boundary conditions**
- A write in the same cycle as an accept is not visible: `wsnap` takes the pre-write `wptr`.
- Writes during READ or OUT do not alter the snapshot.
- Read memory is combinational from the register arrays, one channel per cycle. No read-during-write hazard exists because read addresses never equal `wptr`.
- Reset mid-READ or mid-OUT drops the request immediately: IDLE, `o_sum_valid`=0, `fill`=0.
- `wptr` wraps from 255 to 0 with no gap.

## Structure

**Shared package `beamform_pkg`**
- `NUM_CH`=16.
- `DELTA_W`.
- `DEPTH`.
- State enum {IDLE, READ, OUT}.
- Function for sign-extending a sample to SUM_W.

**Sub-module `sample_ring`**
- One channel: write port, combinational read port, DEPTH×DATA_W storage.
- Instantiated 16 times through `generate`.
- Top level holds the FSM, pointers, snapshot, the 16:1 read mux and the accumulator.

## Test plan

1. **Reset:** reset asserted → all outputs 0 and `o_req_ready`=1 one cycle after release; a request with no frames written gives sum=0 at cycle 17.
2. **Single tap:** write 200 frames where channel k in frame n = n; request all deltas=147 → sum = 16×(199−147) = 832, valid exactly 17 cycles after accept, tag echoed.
3. **Mixed deltas and signs:** channel k constant −(k+1) for 200 frames; deltas 147..162 → sum = −136.
4. **Partial fill:** 150 frames written; deltas 147 for ch0–7 and 160 for ch8–15, each sample 100 → sum = 800, because ch8–15 are masked.
5. **Wrap and concurrency:** write 300 frames (`wptr` wraps), keep writing one frame per cycle during READ; delta 179 on all channels, samples = frame index → sum = 16×(299−179) = 1920, unaffected by the writes.
6. **Backpressure and reset:** hold `i_sum_ready`=0 for 10 cycles → sum and tag stable, `o_req_ready`=0. Then assert `i_rst_n`=0 mid-OUT → `o_sum_valid` drops asynchronously and the next request sees fill=0.
